// File: rtl/jtgng_sdram_arb.sv
// jtgng_sdram_arb: fixed-priority read arbiter with a one-line cache per ROM slot,
// sitting between four ROM consumers and the SDRAM controller read port.
module jtgng_sdram_arb #(
  parameter int AW      = 22,
  parameter int TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  input  logic [3:0]      slot_cs,
  input  logic [4*AW-1:0] slot_addr,
  output logic [3:0]      slot_ok,
  output logic [4*32-1:0] slot_dout,
  output logic [AW-1:0]   sdram_addr,
  output logic            read_req,
  output logic            read_sync,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [31:0]     data_read
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [AW-1:0] sdramAddr_q, sdramAddr_d;
  logic          readReq_q, readReq_d;
  logic          readSync_q, readSync_d;
  logic [AW-1:0] cachedAddr_q [4];
  logic [AW-1:0] cachedAddr_d [4];
  logic [31:0]   cachedData_q [4];
  logic [31:0]   cachedData_d [4];
  logic [3:0]    valid_q, valid_d;

  logic [3:0]    slotOk;
  logic [3:0]    miss;
  logic          anyMiss;
  logic [1:0]    missSel;
  logic [AW-1:0] missAddr;
  logic          timeoutHit;

  // Hit/miss per slot: a slot is served when its cached line matches the current address
  always_comb begin
    slotOk = '0;
    miss   = '0;
    for (int n = 0; n < 4; n++) begin
      slotOk[n] = slot_cs[n] & valid_q[n] & (slot_addr[n*AW +: AW] == cachedAddr_q[n]);
      miss[n]   = slot_cs[n] & ~slotOk[n] & ~downloading;
    end
  end

  // Fixed priority pick of the lowest-numbered missing slot and its address
  always_comb begin
    missSel  = '0;
    missAddr = '0;
    for (int n = 3; n >= 0; n--) begin
      if (miss[n]) begin
        missSel  = 2'(n);
        missAddr = slot_addr[n*AW +: AW];
      end
    end
  end

  assign anyMiss    = |miss;
  assign timeoutHit = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a download forces the machine back to IDLE and ignores the controller
  always_comb begin
    state_d = state_q;
    if (downloading) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (anyMiss) state_d = WAIT_ACK;
        WAIT_ACK:  if (timeoutHit) state_d = IDLE;
                   else if (sdram_ack) state_d = WAIT_DATA;
        WAIT_DATA: if (data_rdy || timeoutHit) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: request issue, timeout counting and cache fill
  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    sdramAddr_d  = sdramAddr_q;
    readReq_d    = readReq_q;
    readSync_d   = readSync_q;
    cachedAddr_d = cachedAddr_q;
    cachedData_d = cachedData_q;
    valid_d      = valid_q;
    if (downloading) begin
      readReq_d = 1'b0;
      valid_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyMiss) begin
            sdramAddr_d = missAddr;
            sel_d       = missSel;
            readSync_d  = ~readSync_q;
            readReq_d   = 1'b1;
            cnt_d       = '0;
          end else begin
            readReq_d = 1'b0;
          end
        end
        WAIT_ACK: begin
          if (timeoutHit) readReq_d = 1'b0;
          else            cnt_d     = cnt_q + CW'(1);
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            cachedData_d[sel_q] = data_read;
            cachedAddr_d[sel_q] = sdramAddr_q;
            valid_d[sel_q]      = 1'b1;
            readReq_d           = 1'b0;
          end else if (timeoutHit) begin
            readReq_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: readReq_d = 1'b0;
      endcase
    end
  end

  // Datapath and cache registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      sdramAddr_q <= '0;
      readReq_q   <= 1'b0;
      readSync_q  <= 1'b0;
      valid_q     <= '0;
      for (int n = 0; n < 4; n++) begin
        cachedAddr_q[n] <= '0;
        cachedData_q[n] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sdramAddr_q  <= sdramAddr_d;
      readReq_q    <= readReq_d;
      readSync_q   <= readSync_d;
      valid_q      <= valid_d;
      cachedAddr_q <= cachedAddr_d;
      cachedData_q <= cachedData_d;
    end
  end

  // Output packing of the cached lines
  always_comb begin
    slot_dout = '0;
    for (int n = 0; n < 4; n++) slot_dout[n*32 +: 32] = cachedData_q[n];
  end

  assign slot_ok    = slotOk;
  assign sdram_addr = sdramAddr_q;
  assign read_req   = readReq_q;
  assign read_sync  = readSync_q;

endmodule

// File: tb/tb_jtgng_sdram_arb.sv
// tb_jtgng_sdram_arb: directed bench with a controller model and a request scoreboard.
module tb_jtgng_sdram_arb;

  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            rst;
  logic            downloading;
  logic [3:0]      slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [127:0]    slot_dout;
  logic [AW-1:0]   sdram_addr;
  logic            read_req;
  logic            read_sync;
  logic            sdram_ack;
  logic            data_rdy;
  logic [31:0]     data_read;

  typedef struct {
    logic [AW-1:0] addr;
    bit            chkGap;
    int            gap;
  } req_t;

  req_t reqQ[$];
  int   checks = 0;
  int   errors = 0;
  int   ctrlMode = 0;   // 0: ack then data, 1: ack but never data

  jtgng_sdram_arb #(.AW(AW), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_addr(sdram_addr), .read_req(read_req), .read_sync(read_sync),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read)
  );

  always #5 clk = ~clk;

  // Line contents the controller model returns for a given address
  function automatic logic [31:0] dataFor(input logic [AW-1:0] a);
    if (a == 22'h100) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cs, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    slot_cs   = cs;
    slot_addr = {a3, a2, a1, a0};
  endtask

  task automatic expectReq(input logic [AW-1:0] a, input bit chk, input int gap);
    req_t r;
    r.addr = a; r.chkGap = chk; r.gap = gap;
    reqQ.push_back(r);
  endtask

  // Returns the number of consecutive high read_req samples; ends on the first low sample
  task automatic waitHighRun(output int cnt);
    int guard;
    cnt = 0; guard = 0;
    @(negedge clk);
    while (!read_req && guard < 20) begin @(negedge clk); guard++; end
    while (read_req && cnt < 200) begin cnt++; @(negedge clk); end
  endtask

  task automatic waitOk(input logic [3:0] mask, input string name);
    int guard = 0;
    while (slot_ok !== mask && guard < 400) begin @(negedge clk); guard++; end
    checkOutput(name, slot_ok, mask);
  endtask

  task automatic waitAck(input string name);
    int guard = 0;
    @(posedge clk);
    while (!sdram_ack && guard < 20) begin @(posedge clk); guard++; end
    checkOutput(name, sdram_ack, 1'b1);
  endtask

  // Controller model: ack sampled on the 4th rising edge after issue, data on the 9th
  initial begin
    logic          lastSync;
    logic [AW-1:0] reqAddr;
    bit            sawRst;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0; lastSync = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lastSync = read_sync;
      end else if (read_sync !== lastSync) begin
        lastSync = read_sync;
        reqAddr  = sdram_addr;
        sawRst   = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (rst) sawRst = 1'b1; end
        sdram_ack = 1'b1;
        @(negedge clk); if (rst) sawRst = 1'b1;
        sdram_ack = 1'b0;
        if (ctrlMode == 0) begin
          for (int i = 0; i < 4; i++) begin @(negedge clk); if (rst) sawRst = 1'b1; end
          data_read = dataFor(reqAddr);
          data_rdy  = 1'b1;
          @(negedge clk); if (rst) sawRst = 1'b1;
          data_rdy  = 1'b0;
        end
        if (sawRst) lastSync = read_sync;
      end
    end
  end

  // Monitor: every read_sync toggle is a request; compare against the scoreboard queue
  initial begin
    logic prevSync;
    int   lowRun;
    req_t e;
    prevSync = 1'b0; lowRun = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevSync = read_sync;
        lowRun   = 0;
      end else begin
        if (read_sync !== prevSync) begin
          prevSync = read_sync;
          if (reqQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_req: got addr %0h expected no request", sdram_addr);
          end else begin
            e = reqQ.pop_front();
            checkOutput("req_addr", sdram_addr, e.addr);
            if (e.chkGap) checkOutput("req_gap", lowRun, e.gap);
          end
        end
        if (read_req) lowRun = 0;
        else          lowRun++;
      end
    end
  end

  initial begin
    int cnt;
    int guard;
    rst = 1'b1; downloading = 1'b0;
    applyStimulus(4'b0000, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_slot_ok", slot_ok, 4'b0);
    checkOutput("rst_slot_dout", slot_dout, 128'b0);
    checkOutput("rst_sdram_addr", sdram_addr, 22'h0);
    checkOutput("rst_read_req", read_req, 1'b0);
    checkOutput("rst_read_sync", read_sync, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single miss then hit");
    expectReq(22'h100, 1'b0, 0);
    applyStimulus(4'b0001, 22'h100, '0, '0, '0);
    waitHighRun(cnt);
    checkOutput("t1_req_len", cnt, 9);
    checkOutput("t1_ok", slot_ok, 4'b0001);
    checkOutput("t1_dout0", slot_dout[31:0], 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    checkOutput("t1_no_reissue_req", read_req, 1'b0);
    checkOutput("t1_sync_once", read_sync, 1'b1);
    checkOutput("t1_still_ok", slot_ok, 4'b0001);

    $display("[TB] three simultaneous misses");
    expectReq(22'h010, 1'b0, 0);
    expectReq(22'h011, 1'b1, 1);
    expectReq(22'h033, 1'b1, 1);
    applyStimulus(4'b1011, 22'h010, 22'h011, 22'h0, 22'h033);
    @(negedge clk);
    waitOk(4'b1011, "t2_all_ok");
    checkOutput("t2_dout0", slot_dout[31:0], 32'hC0DE0010);
    checkOutput("t2_dout1", slot_dout[63:32], 32'hC0DE0011);
    checkOutput("t2_dout3", slot_dout[127:96], 32'hC0DE0033);
    checkOutput("t2_sync", read_sync, 1'b0);

    $display("[TB] address change in flight");
    expectReq(22'h200, 1'b0, 0);
    expectReq(22'h204, 1'b1, 1);
    applyStimulus(4'b0100, 22'h010, 22'h011, 22'h200, 22'h033);
    waitAck("t3_ack");
    @(negedge clk);
    slot_addr[2*AW +: AW] = 22'h204;
    guard = 0;
    while (read_req && guard < 100) begin @(negedge clk); guard++; end
    checkOutput("t3_ok_after_stale_fill", slot_ok, 4'b0000);
    checkOutput("t3_stale_line", slot_dout[95:64], 32'hC0DE0200);
    waitOk(4'b0100, "t3_ok_refetch");
    checkOutput("t3_new_line", slot_dout[95:64], 32'hC0DE0204);

    $display("[TB] timeout and re-issue");
    ctrlMode = 1;
    expectReq(22'h400, 1'b0, 0);
    expectReq(22'h400, 1'b1, 1);
    applyStimulus(4'b0010, 22'h010, 22'h400, 22'h204, 22'h033);
    waitHighRun(cnt);
    checkOutput("t4_first_len", cnt, 63);
    waitHighRun(cnt);
    checkOutput("t4_second_len", cnt, 63);
    checkOutput("t4_not_ok", slot_ok, 4'b0000);
    checkOutput("t4_line_kept", slot_dout[63:32], 32'hC0DE0011);
    slot_cs  = 4'b0000;
    ctrlMode = 0;
    repeat (4) @(negedge clk);
    checkOutput("t4_idle", read_req, 1'b0);

    $display("[TB] download pulse");
    applyStimulus(4'b1111, 22'h010, 22'h011, 22'h204, 22'h033);
    @(negedge clk);
    checkOutput("t5_all_hit", slot_ok, 4'b1111);
    expectReq(22'h010, 1'b0, 0);
    expectReq(22'h011, 1'b1, 1);
    expectReq(22'h204, 1'b1, 1);
    expectReq(22'h033, 1'b1, 1);
    downloading = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t5_dl_ok", slot_ok, 4'b0000);
      checkOutput("t5_dl_req", read_req, 1'b0);
    end
    downloading = 1'b0;
    waitOk(4'b1111, "t5_refetched");
    checkOutput("t5_dout", slot_dout, {32'hC0DE0033, 32'hC0DE0204, 32'hC0DE0011, 32'hC0DE0010});

    $display("[TB] reset in flight");
    expectReq(22'h300, 1'b0, 0);
    applyStimulus(4'b0001, 22'h300, 22'h011, 22'h204, 22'h033);
    waitAck("t6_ack");
    @(negedge clk);
    @(negedge clk);
    slot_cs = 4'b0000;
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_req", read_req, 1'b0);
    checkOutput("t6_rst_sync", read_sync, 1'b0);
    checkOutput("t6_rst_addr", sdram_addr, 22'h0);
    checkOutput("t6_rst_dout", slot_dout, 128'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_late_data_req", read_req, 1'b0);
    checkOutput("t6_late_data_dout", slot_dout, 128'b0);
    expectReq(22'h300, 1'b0, 0);
    slot_cs = 4'b0001;
    #1;
    checkOutput("t6_not_cached", slot_ok, 4'b0000);
    waitOk(4'b0001, "t6_refetch_ok");
    checkOutput("t6_refetch_dout", slot_dout[31:0], 32'hC0DE0300);

    repeat (10) @(negedge clk);
    checkOutput("queue_drained", reqQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
